// File: rtl/ysyx_23060191_mem_arbiter_pkg.sv
// Shared constants for the IFU/LSU memory arbiter: FSM encodings, owner ids, timeout default.
// Latency: none (declarations only).
// Backpressure: not applicable.
package ysyx_23060191_mem_arbiter_pkg;

    // Arbiter FSM encodings (2-bit, kept as plain constants for legacy tools)
    localparam logic [1:0] ARB_ST_IDLE = 2'd0;
    localparam logic [1:0] ARB_ST_REQ  = 2'd1;
    localparam logic [1:0] ARB_ST_RESP = 2'd2;
    localparam logic [1:0] ARB_ST_DONE = 2'd3;

    // Owner ids double as bit positions in the request/grant vectors
    localparam logic ARB_OWNER_IFU = 1'b0;
    localparam logic ARB_OWNER_LSU = 1'b1;

    // Cycles a transaction may spend in REQ+RESP before it is failed
    localparam int ARB_TIMEOUT_DEFAULT = 255;

    // One-hot grant vector for a given owner id
    function automatic logic [1:0] arb_owner_onehot(input logic owner);
        return (owner == ARB_OWNER_LSU) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ysyx_23060191_rr_arb2.sv
// Two-input round-robin picker: one-hot grant, the master that did not win last time wins a tie.
// Latency: purely combinational.
// Backpressure: enable low forces an empty grant (arbiter busy).
module ysyx_23060191_rr_arb2
    import ysyx_23060191_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    // Single requester wins outright; on a tie the other master than last_grant wins
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = arb_owner_onehot(~last_grant);
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/ysyx_23060191_mem_arbiter.sv
// IFU/LSU to single memory port arbiter: round-robin grant, one outstanding transaction, slave timeout.
// Latency: accept at cycle 0, mem request from cycle 1, master response pulse no earlier than cycle 3.
// Backpressure: masters are held off (req_ready low) outside IDLE; responses cannot be stalled.
module ysyx_23060191_mem_arbiter
    import ysyx_23060191_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
)
(
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_resp_rdata,
    output logic                ifu_resp_err,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_resp_rdata,
    output logic                lsu_resp_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_rdata
);

    localparam int              TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic                owner;
    logic                last_grant;
    logic [TMR_W-1:0]    timer;

    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wmask_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

    logic                arb_enable;
    logic [1:0]          grant;
    logic                accept;
    logic                pick;
    logic                in_flight;
    logic                complete;
    logic                expire;

    // Grants only happen in IDLE; reset also masks the combinational ready path
    assign arb_enable = (state == ARB_ST_IDLE) && !rst;

    ysyx_23060191_rr_arb2 u_rr_arb2 (
        .req        ({lsu_req_valid, ifu_req_valid}),
        .last_grant (last_grant),
        .enable     (arb_enable),
        .grant      (grant)
    );

    assign ifu_req_ready = grant[ARB_OWNER_IFU];
    assign lsu_req_ready = grant[ARB_OWNER_LSU];
    assign accept        = |grant;
    assign pick          = grant[ARB_OWNER_LSU] ? ARB_OWNER_LSU : ARB_OWNER_IFU;

    // A response seen while still in REQ is ignored: the slave must answer after accepting
    assign in_flight = (state == ARB_ST_REQ) || (state == ARB_ST_RESP);
    assign complete  = (state == ARB_ST_RESP) && mem_resp_valid;
    assign expire    = in_flight && (timer == TMR_LAST) && !complete;

    assign mem_req_valid = (state == ARB_ST_REQ);
    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;

    // Both masters see the shared response registers; only resp_valid qualifies them
    assign ifu_resp_valid = (state == ARB_ST_DONE) && (owner == ARB_OWNER_IFU);
    assign lsu_resp_valid = (state == ARB_ST_DONE) && (owner == ARB_OWNER_LSU);
    assign ifu_resp_rdata = rdata_q;
    assign lsu_resp_rdata = rdata_q;
    assign ifu_resp_err   = err_q;
    assign lsu_resp_err   = err_q;

    // Next-state: timeout preempts a REQ handshake, completion beats timeout in RESP
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_ST_IDLE: begin
                if (accept) begin
                    state_nxt = ARB_ST_REQ;
                end
            end
            ARB_ST_REQ: begin
                if (expire) begin
                    state_nxt = ARB_ST_DONE;
                end else if (mem_req_ready) begin
                    state_nxt = ARB_ST_RESP;
                end
            end
            ARB_ST_RESP: begin
                if (complete || expire) begin
                    state_nxt = ARB_ST_DONE;
                end
            end
            ARB_ST_DONE: begin
                state_nxt = ARB_ST_IDLE;
            end
            default: begin
                state_nxt = ARB_ST_IDLE;
            end
        endcase
    end

    // FSM state register; reset abandons any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the granted request and remember who won; IFU fetches carry no write payload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= ARB_OWNER_IFU;
            last_grant <= ARB_OWNER_LSU;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
        end else if (accept) begin
            owner      <= pick;
            last_grant <= pick;
            if (pick == ARB_OWNER_LSU) begin
                addr_q  <= lsu_req_addr;
                wen_q   <= lsu_req_wen;
                wdata_q <= lsu_req_wdata;
                wmask_q <= lsu_req_wmask;
            end else begin
                addr_q  <= ifu_req_addr;
                wen_q   <= 1'b0;
                wdata_q <= '0;
                wmask_q <= '0;
            end
        end
    end

    // Timeout counter: cleared on accept, advances every cycle the slave holds the transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (accept) begin
            timer <= '0;
        end else if (in_flight) begin
            timer <= timer + 1'b1;
        end
    end

    // Response capture: store completions return zero data, a timeout returns an error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (complete) begin
            rdata_q <= wen_q ? '0 : mem_resp_rdata;
            err_q   <= 1'b0;
        end else if (expire) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
        end
    end

endmodule
